// File: rtl/intc_seq_if.sv
// Bundle of request, control-unit and datapath-sequencing signals shared
// between the interrupt controller and the CPU core.
interface intc_seq_if #(
  parameter int N_IRQ = 8,
  parameter int PC_W  = 10
);
  logic [N_IRQ-1:0] irq;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wd;
  logic             gie_set;
  logic             gie_clr;
  logic             reti;
  logic             stack_full;
  logic             int_take;
  logic             push;
  logic             squash;
  logic [PC_W-1:0]  vector;
  logic [2:0]       irq_id;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] isr;
  logic             gie;

  modport slave (
    input  irq, mask_we, mask_wd, gie_set, gie_clr, reti, stack_full,
    output int_take, push, squash, vector, irq_id, pending, isr, gie
  );

  modport master (
    output irq, mask_we, mask_wd, gie_set, gie_clr, reti, stack_full,
    input  int_take, push, squash, vector, irq_id, pending, isr, gie
  );
endinterface

// File: rtl/intc_seq.sv
// Vectored interrupt controller: synchronises and edge-detects request lines,
// arbitrates by fixed priority and sequences the one-cycle datapath entry.
module intc_seq #(
  parameter int          N_IRQ      = 8,
  parameter int          PC_W       = 10,
  parameter int unsigned VEC_BASE   = 32'h3C0,
  parameter int unsigned VEC_STRIDE = 4
) (
  input  logic      clk,
  input  logic      reset,
  intc_seq_if.slave bus
);
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_ENTER = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [N_IRQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] isr_q, isr_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic             gie_q, gie_d;
  logic [1:0]       state_q, state_d;
  logic [2:0]       irq_id_q, irq_id_d;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] accept;
  logic             cand_vld, cand_ok, isr_seen;
  logic [2:0]       cand_id;
  logic             eligible;
  logic             entering;
  logic [PC_W-1:0]  vec_addr;

  always_comb begin
    sync1_d = bus.irq;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;

    entering = (state_q == ST_ENTER);
    accept   = entering ? (N_IRQ'(1) << irq_id_q) : '0;

    // Ascending scan: the first pending+enabled line is the candidate; it is
    // blocked if any in-service bit at or above its priority was seen.
    cand_vld = 1'b0;
    cand_ok  = 1'b0;
    cand_id  = '0;
    isr_seen = 1'b0;
    for (int i = 0; i < N_IRQ; i++) begin
      isr_seen = isr_seen | isr_q[i];
      if (!cand_vld && pending_q[i] && mask_q[i]) begin
        cand_vld = 1'b1;
        cand_id  = 3'(i);
        cand_ok  = !isr_seen;
      end
    end

    eligible = cand_vld && cand_ok && gie_q && (state_q == ST_RUN) &&
               !bus.stack_full && !bus.reti;

    // Set wins over accept so a rise during ENTER is not lost.
    pending_d = (pending_q & ~accept) | rise;

    isr_d = isr_q;
    if (entering) begin
      isr_d = isr_q | accept;
    end else if (bus.reti && (isr_q != '0)) begin
      isr_d = isr_q & (isr_q - N_IRQ'(1));
    end

    mask_d = bus.mask_we ? bus.mask_wd : mask_q;

    gie_d = gie_q;
    if (bus.gie_clr) begin
      gie_d = 1'b0;
    end else if (bus.gie_set) begin
      gie_d = 1'b1;
    end

    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      ST_RUN: begin
        if (eligible) begin
          state_d  = ST_ENTER;
          irq_id_d = cand_id;
        end
      end
      ST_ENTER: state_d = ST_HOLD;
      default:  state_d = ST_RUN;
    endcase

    vec_addr = PC_W'(VEC_BASE) + PC_W'(32'(irq_id_q) * VEC_STRIDE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      isr_q     <= '0;
      mask_q    <= '0;
      gie_q     <= 1'b0;
      state_q   <= ST_RUN;
      irq_id_q  <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      isr_q     <= isr_d;
      mask_q    <= mask_d;
      gie_q     <= gie_d;
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
    end
  end

  // Sequencing strobes decode registered state only, so they cannot glitch.
  assign bus.int_take = entering;
  assign bus.push     = entering;
  assign bus.squash   = entering;
  assign bus.vector   = entering ? vec_addr : '0;
  assign bus.irq_id   = entering ? irq_id_q : '0;
  assign bus.pending  = pending_q;
  assign bus.isr      = isr_q;
  assign bus.gie      = gie_q;
endmodule

// File: tb/tb_intc_seq.sv
// Randomised and directed bench for intc_seq; a priority/service model in
// the bench feeds an entry scoreboard checked by an independent monitor.
module tb_intc_seq;
  localparam int N   = 8;
  localparam int PCW = 10;
  localparam int VB  = 'h3C0;
  localparam int VS  = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  intc_seq_if #(.N_IRQ(N), .PC_W(PCW)) bus();

  intc_seq #(.N_IRQ(N), .PC_W(PCW), .VEC_BASE(VB), .VEC_STRIDE(VS)) u_dut (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int id; int vec; } entry_t;
  entry_t exp_q[$];

  // Reference model: raw samples history, request sets and a phase counter.
  logic [N-1:0] m_hist [3];
  logic [N-1:0] m_pending, m_isr, m_mask;
  logic         m_gie;
  int           m_phase;   // 0 = running, 1 = entering, 2 = first ISR cycle
  int           m_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_hist[k] = '0;
    m_pending = '0; m_isr = '0; m_mask = '0; m_gie = 1'b0;
    m_phase = 0; m_id = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [N-1:0] rise, nxt_pend, nxt_isr;
    int cand, top_isr;
    entry_t e;
    if (!reset_n) begin
      model_reset();
      return;
    end
    // A request is a sample that is high when the one before it was low,
    // seen two samples late through the synchroniser.
    rise     = m_hist[1] & ~m_hist[2];
    nxt_pend = m_pending;
    nxt_isr  = m_isr;
    cand     = lowest_set(m_pending & m_mask);
    top_isr  = lowest_set(m_isr);
    case (m_phase)
      0: begin
        if (bus.reti && m_isr != '0) nxt_isr[top_isr] = 1'b0;
        if (cand >= 0 && m_gie && !bus.stack_full && !bus.reti &&
            (top_isr < 0 || top_isr > cand)) begin
          m_phase = 1;
          m_id    = cand;
          e.id    = cand;
          e.vec   = (VB + cand * VS) % (1 << PCW);
          exp_q.push_back(e);
        end
      end
      1: begin
        nxt_pend[m_id] = 1'b0;
        nxt_isr[m_id]  = 1'b1;
        m_phase = 2;
      end
      default: begin
        if (bus.reti && m_isr != '0) nxt_isr[top_isr] = 1'b0;
        m_phase = 0;
      end
    endcase
    m_pending = nxt_pend | rise;
    m_isr     = nxt_isr;
    if (bus.gie_clr) m_gie = 1'b0;
    else if (bus.gie_set) m_gie = 1'b1;
    if (bus.mask_we) m_mask = bus.mask_wd;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = bus.irq;
  endtask

  initial begin
    entry_t e;
    forever begin
      @(posedge clk);
      #2;
      check("int_take", 32'(bus.int_take), 32'(m_phase == 1));
      check("push",     32'(bus.push),     32'(m_phase == 1));
      check("squash",   32'(bus.squash),   32'(m_phase == 1));
      check("pending",  32'(bus.pending),  32'(m_pending));
      check("isr",      32'(bus.isr),      32'(m_isr));
      check("gie",      32'(bus.gie),      32'(m_gie));
      if (bus.int_take) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_take: got irq_id %0d expected no entry", bus.irq_id);
        end else begin
          e = exp_q.pop_front();
          check("sb_irq_id", 32'(bus.irq_id), 32'(e.id));
          check("sb_vector", 32'(bus.vector), 32'(e.vec));
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wait_take(input string name, input int exp_id, input int budget);
    int k = 0;
    while (!bus.int_take && k < budget) begin
      cycle();
      k++;
    end
    if (!bus.int_take) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no int_take within %0d cycles expected entry of line %0d", name, budget, exp_id);
    end else begin
      check({name, "_id"},  32'(bus.irq_id), 32'(exp_id));
      check({name, "_vec"}, 32'(bus.vector), 32'(VB + exp_id * VS));
    end
  endtask

  task automatic reti_pulse();
    bus.reti = 1'b1; cycle(); bus.reti = 1'b0;
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    bus.mask_we = 1'b1; bus.mask_wd = m; cycle(); bus.mask_we = 1'b0;
  endtask

  task automatic gie_pulse(input logic set, input logic clr);
    bus.gie_set = set; bus.gie_clr = clr; cycle();
    bus.gie_set = 1'b0; bus.gie_clr = 1'b0;
  endtask

  initial begin
    int cnt;
    bus.irq = '0; bus.mask_we = 1'b0; bus.mask_wd = '0; bus.gie_set = 1'b0;
    bus.gie_clr = 1'b0; bus.reti = 1'b0; bus.stack_full = 1'b0;
    model_reset();
    #2;
    check("rst_int_take", 32'(bus.int_take), 32'd0);
    check("rst_push",     32'(bus.push),     32'd0);
    check("rst_pending",  32'(bus.pending),  32'd0);
    check("rst_isr",      32'(bus.isr),      32'd0);
    check("rst_gie",      32'(bus.gie),      32'd0);
    cycles(3);
    reset_n = 1'b1;
    cycles(2);

    // Basic entry on line 2
    write_mask(8'h04);
    gie_pulse(1'b1, 1'b0);
    bus.irq[2] = 1'b1;
    cycles(3);
    check("basic_pending", 32'(bus.pending), 32'h04);
    wait_take("basic", 2, 1);
    cycle();
    check("basic_isr", 32'(bus.isr), 32'h04);
    check("basic_pend_clr", 32'(bus.pending), 32'h00);
    bus.irq[2] = 1'b0;
    cycles(3);
    reti_pulse();
    cycles(2);

    // Priority between simultaneous lines 5 and 1
    write_mask(8'hFF);
    bus.irq = 8'h22;
    wait_take("prio_first", 1, 8);
    cycles(3);
    bus.irq = '0;
    reti_pulse();
    wait_take("prio_second", 5, 3);
    cycles(3);
    reti_pulse();
    cycles(2);

    // Nesting: 6 waits behind 4, 0 preempts 4
    bus.irq[4] = 1'b1;
    wait_take("nest4", 4, 8);
    cycles(2);
    bus.irq[6] = 1'b1;
    cycles(6);
    check("nest_pend6", 32'(bus.pending[6]), 32'd1);
    bus.irq[0] = 1'b1;
    wait_take("nest0", 0, 8);
    cycles(2);
    check("nest_isr", 32'(bus.isr), 32'h11);
    reti_pulse();
    cycles(2);
    check("nest_isr_after1", 32'(bus.isr), 32'h10);
    reti_pulse();
    wait_take("nest6", 6, 3);
    cycles(2);
    reti_pulse();
    bus.irq = '0;
    cycles(3);

    // Blocking by stack_full, gie and mask
    bus.stack_full = 1'b1;
    bus.irq[3] = 1'b1;
    cycles(8);
    check("blk_stack_pend", 32'(bus.pending), 32'h08);
    bus.stack_full = 1'b0;
    wait_take("unblk_stack", 3, 1);
    cycles(2); reti_pulse(); bus.irq[3] = 1'b0; cycles(3);

    gie_pulse(1'b0, 1'b1);
    bus.irq[3] = 1'b1;
    cycles(8);
    check("blk_gie_pend", 32'(bus.pending), 32'h08);
    gie_pulse(1'b1, 1'b0);
    wait_take("unblk_gie", 3, 1);
    cycles(2); reti_pulse(); bus.irq[3] = 1'b0; cycles(3);

    write_mask(8'hF7);
    bus.irq[3] = 1'b1;
    cycles(8);
    check("blk_mask_pend", 32'(bus.pending), 32'h08);
    write_mask(8'hFF);
    wait_take("unblk_mask", 3, 1);
    cycles(2); reti_pulse(); bus.irq[3] = 1'b0; cycles(3);

    // Simultaneous set and clear of the global enable
    gie_pulse(1'b1, 1'b1);
    check("gie_both", 32'(bus.gie), 32'd0);
    gie_pulse(1'b1, 1'b0);

    // Level held high yields one entry
    bus.irq[7] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (bus.int_take) cnt++;
    end
    check("held_once", 32'(cnt), 32'd1);
    reti_pulse();
    bus.irq[7] = 1'b0;
    cycles(3);

    // New rise on line 3 lands during its own ENTER cycle
    bus.irq[3] = 1'b1; cycle();
    bus.irq[3] = 1'b0; cycle();
    bus.irq[3] = 1'b1;
    wait_take("rise_in_enter", 3, 6);
    cycle();
    check("rise_in_enter_pend", 32'(bus.pending[3]), 32'd1);
    cycles(2);
    reti_pulse();
    cycles(6);
    reti_pulse();
    bus.irq = '0;
    cycles(3);

    // Asynchronous reset in the middle of ENTER
    bus.irq[1] = 1'b1;
    wait_take("rst_enter", 1, 8);
    reset_n = 1'b0;
    model_reset();
    #2;
    check("arst_int_take", 32'(bus.int_take), 32'd0);
    check("arst_push",     32'(bus.push),     32'd0);
    check("arst_squash",   32'(bus.squash),   32'd0);
    check("arst_pending",  32'(bus.pending),  32'd0);
    bus.irq = '0;
    cycles(3);
    reset_n = 1'b1;
    cycles(10);
    check("arst_no_entry", 32'(bus.isr), 32'd0);

    // Randomised traffic
    write_mask(8'hFF);
    gie_pulse(1'b1, 1'b0);
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) bus.irq[i] = ~bus.irq[i];
      bus.reti       = ($urandom_range(5) == 0);
      bus.stack_full = ($urandom_range(7) == 0);
      bus.mask_we    = ($urandom_range(29) == 0);
      bus.mask_wd    = N'($urandom);
      bus.gie_set    = ($urandom_range(9) == 0);
      bus.gie_clr    = ($urandom_range(39) == 0);
      cycle();
    end
    bus.irq = '0; bus.reti = 1'b0; bus.stack_full = 1'b0; bus.mask_we = 1'b0;
    bus.gie_set = 1'b0; bus.gie_clr = 1'b0;
    cycles(10);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
